lcd_text_driver: RTL and testbench
==================================

Name: lcd_text_driver

Overview:
- Downstream consumer of the 256-bit character image assembled by the display top level.
- Initialises an HD44780-compatible character LCD in 4-bit write-only mode.
- Continuously refreshes both 16-character lines from a per-frame snapshot of `chars`.
- Drives the starter-board LCD pins directly; no read-back and no busy-flag polling, only timed waits.

Parameters:
- `T_POWERUP`, 750000: cycles of power-on wait before the first init nibble (15 ms at 50 MHz).
- `T_INIT1`, 205000: wait after the first 0x3 nibble (4.1 ms).
- `T_INIT2`, 5000: wait after the second 0x3 nibble (100 us).
- `T_CMD`, 2000: wait after the third 0x3, after the 0x2 nibble and after every full byte (40 us).
- `T_CLEAR`, 82000: wait after the clear-display command (1.64 ms).
- `T_SETUP`, 2: cycles RS/data are stable before E rises.
- `T_EHIGH`, 12: cycles E is held high.
- `T_NIBGAP`, 50: cycles from E fall to the next nibble of the same byte (1 us).

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: synchronous reset, active-low.
- `chars`, input, 256: 32 ASCII bytes. [255:248] is line 1 col 0 … [135:128] is line 1 col 15; [127:120] is line 2 col 0 … [7:0] is line 2 col 15.
- `frame_done`, output, 1: one-cycle pulse after the last character of each frame is written.
- `lcd_rs`, output, 1: register select (0 = command, 1 = data).
- `lcd_rw`, output, 1: read/write select; tied 0.
- `lcd_e`, output, 1: enable strobe.
- `lcd_4`, `lcd_5`, `lcd_6`, `lcd_7`, output, 1 each: data nibble D4..D7.

Behaviour:
- One clock `clk`; reset `rst_n` is synchronous and active-low.
- All state changes happen on the rising edge of `clk`.

Reset values (while `rst_n` = 0):
- `lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_4`..`lcd_7`, `frame_done` all = 0.
- The FSM enters `PWR_WAIT` with its delay counter cleared.
- Deasserting reset mid-frame or mid-strobe restarts the full power-up sequence.
- `lcd_e` never stays high across reset.

Nibble write (handled by the sub-module):
1. Drive RS and the nibble.
2. Wait `T_SETUP` cycles.
3. Hold `lcd_e` = 1 for exactly `T_EHIGH` cycles.
4. Drop `lcd_e` to 0.
5. Keep RS/data stable 1 cycle after E falls.

Byte write:
- High nibble first, then a `T_NIBGAP` gap, then the low nibble.
- Followed by the post-byte wait (`T_CMD`, or `T_CLEAR` for command 0x01).

FSM states and transitions:
- `PWR_WAIT` (`T_POWERUP`) -> `INIT_3A`.
- `INIT_3A`: nibble 0x3, wait `T_INIT1` -> `INIT_3B`.
- `INIT_3B`: nibble 0x3, wait `T_INIT2` -> `INIT_3C`.
- `INIT_3C`: nibble 0x3, wait `T_CMD` -> `INIT_2`.
- `INIT_2`: nibble 0x2, wait `T_CMD` -> `CFG`.
- `CFG`: bytes 0x28, 0x06, 0x0C, 0x01 in that order, all with RS = 0 -> `SNAP`.
- `SNAP`: copy `chars` into the internal 256-bit frame register (one cycle) -> `ADDR1`.
- `ADDR1`: command 0x80 -> `LINE1`.
- `LINE1`: 16 data bytes (RS = 1), column counter 0..15 -> `ADDR2`.
- `ADDR2`: command 0xC0 -> `LINE2`.
- `LINE2`: 16 data bytes -> `DONE`.
- `DONE`: pulse `frame_done` for 1 cycle -> `SNAP`. The loop repeats forever; the init sequence never repeats except after reset.

Data and timing rules:
- `chars` is sampled only in `SNAP`. Changes mid-frame take effect on the next frame; there is no tearing.
- Character index = line*16 + col. The byte is selected as frame[255 - 8*idx -: 8].
- Any byte value, including 0x00 and 0xFF, is written verbatim.
- Delay counter is 20 bits (covers `T_POWERUP`), loaded on entry and counting down to 0.
- All waits are exact: a wait of N means N idle cycles after E falls.
- `lcd_rw` = 0 at all times.

Decomposition:
- Package `lcd_pkg` holds:
  - the FSM state enumeration;
  - the command constants `CMD_FUNCSET` = 0x28, `CMD_ENTRY` = 0x06, `CMD_DISPON` = 0x0C, `CMD_CLEAR` = 0x01, `CMD_LINE1` = 0x80, `CMD_LINE2` = 0xC0;
  - the init nibble constants 0x3 and 0x2.
- Sub-module `lcd_nibble_writer`:
  - inputs: `start`, `rs`, `nibble`;
  - outputs: `lcd_e`, `lcd_rs`, `lcd_4`..`lcd_7`, `done` (1-cycle pulse);
  - owns the `T_SETUP`/`T_EHIGH`/hold timing.
- `lcd_text_driver` owns the sequencing, the waits and the character indexing.

Test Plan:
1. Reset then release with reduced timing (`T_POWERUP`=100, `T_INIT1`=40, `T_INIT2`=20, `T_CMD`=10, `T_CLEAR`=30, `T_NIBGAP`=5) -> first E rise exactly at 100+2 cycles after release. Decoded nibble stream 3,3,3,2, then bytes 28,06,0C,01.
2. `chars` = "THIEN" + "21119358 " + 18 spaces -> decoded frame is cmd 80, data 54 48 49 45 4E 32 31 31 31 39 33 35 38 20 20 20, cmd C0, then 16× data 20. RS matches (0 for commands, 1 for data); `frame_done` pulses once.
3. Change `chars` in the middle of `LINE1` -> the current frame completes with the old bytes; the next frame after `frame_done` carries the new bytes.
4. Strobe timing checker on every write -> E high exactly 12 cycles, data/RS stable 2 cycles before the rise and 1 cycle after the fall. Gap between nibbles = 5 cycles; wait after the clear command = 30 cycles; `lcd_rw` never 1.
5. Assert `rst_n` = 0 while E is high during `LINE2` -> E and all outputs are 0 on the next edge. After release the full init sequence (test 1 pattern) reappears before any data byte.
6. Run 3 consecutive frames -> 3 `frame_done` pulses. Frames 2 and 3 contain no init or config bytes, only 80/data/C0/data.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit text driver.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_3A, INIT_3B, INIT_3C, INIT_2, CFG,
    SNAP, ADDR1, LINE1, ADDR2, LINE2, DONE
  } state_t;

  // LOAD primes the power-up wait, DELAY counts an idle gap, BUSY waits for a strobe
  typedef enum logic [1:0] {PH_LOAD, PH_DELAY, PH_BUSY} phase_t;

  localparam logic [7:0] CMD_FUNCSET = 8'h28;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_LINE1   = 8'h80;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;

  localparam logic [3:0] NIB_INIT3 = 4'h3;
  localparam logic [3:0] NIB_INIT2 = 4'h2;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNCSET;
      2'd1:    return CMD_ENTRY;
      2'd2:    return CMD_DISPON;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Writes one nibble to the LCD pins: setup, E-high strobe, then a done pulse.
// RS and data stay on the pins until the next start, so they outlive E.
module lcd_nibble_writer #(
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_4,
  output logic       lcd_5,
  output logic       lcd_6,
  output logic       lcd_7,
  output logic       done
);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_HIGH} wstate_t;

  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] EHIGH_LD = 8'(T_EHIGH - 1);

  wstate_t    st;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= W_IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      {lcd_7, lcd_6, lcd_5, lcd_4} <= 4'h0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        W_IDLE: if (start) begin
          lcd_rs <= rs;
          {lcd_7, lcd_6, lcd_5, lcd_4} <= nibble;
          cnt    <= SETUP_LD;
          st     <= W_SETUP;
        end
        W_SETUP: if (cnt == 8'd0) begin
          lcd_e <= 1'b1;
          cnt   <= EHIGH_LD;
          st    <= W_HIGH;
        end else begin
          cnt <= cnt - 8'd1;
        end
        W_HIGH: if (cnt == 8'd0) begin
          lcd_e <= 1'b0;
          done  <= 1'b1;
          st    <= W_IDLE;
        end else begin
          cnt <= cnt - 8'd1;
        end
        default: st <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// Initialises an HD44780 LCD in 4-bit mode and refreshes both lines forever
// from a per-frame snapshot of chars, using timed waits only.
module lcd_text_driver #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_NIBGAP  = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] chars,
  output logic         frame_done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd_4,
  output logic         lcd_5,
  output logic         lcd_6,
  output logic         lcd_7
);
  import lcd_pkg::*;

  // Counter reloads are trimmed by the cycles spent receiving done, issuing
  // the next start and passing through SNAP/DONE, so every gap after E falls is exact.
  localparam logic [19:0] W_PWR = 20'(T_POWERUP - 3);
  localparam logic [19:0] W_I1  = 20'(T_INIT1 - 2);
  localparam logic [19:0] W_I2  = 20'(T_INIT2 - 2);
  localparam logic [19:0] W_CMD = 20'(T_CMD - 2);
  localparam logic [19:0] W_NIB = 20'(T_NIBGAP - 2);
  localparam logic [19:0] W_CLR = 20'(T_CLEAR - 3);
  localparam logic [19:0] W_END = 20'(T_CMD - 4);

  state_t         state;
  phase_t         phase;
  logic [19:0]    cnt;
  logic           hi;
  logic [1:0]     cfg_i;
  logic [3:0]     col;
  logic [255:0]   frame;

  logic [4:0]     idx;
  logic [7:0]     cur_byte;
  logic [3:0]     nib;
  logic           is_init, writes, rs_cur, start, done;

  always_comb begin
    idx      = {state == LINE2, col};
    is_init  = state inside {INIT_3A, INIT_3B, INIT_3C, INIT_2};
    writes   = is_init || (state inside {CFG, ADDR1, LINE1, ADDR2, LINE2});
    rs_cur   = state inside {LINE1, LINE2};
    case (state)
      CFG:     cur_byte = cfg_byte(cfg_i);
      ADDR1:   cur_byte = CMD_LINE1;
      ADDR2:   cur_byte = CMD_LINE2;
      default: cur_byte = frame[{~idx, 3'b000} +: 8];
    endcase
    if (is_init)
      nib = (state == INIT_2) ? NIB_INIT2 : NIB_INIT3;
    else
      nib = hi ? cur_byte[7:4] : cur_byte[3:0];
    start = (phase == PH_DELAY) && (cnt == 20'd0) && writes;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      phase      <= PH_LOAD;
      cnt        <= '0;
      hi         <= 1'b1;
      cfg_i      <= 2'd0;
      col        <= 4'd0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (phase)
        PH_LOAD: begin
          cnt   <= W_PWR;
          phase <= PH_DELAY;
        end
        PH_DELAY: if (cnt != 20'd0) begin
          cnt <= cnt - 20'd1;
        end else begin
          case (state)
            PWR_WAIT: state <= INIT_3A;
            SNAP: begin
              frame <= chars;
              state <= ADDR1;
            end
            DONE: begin
              frame_done <= 1'b1;
              state      <= SNAP;
            end
            default: phase <= PH_BUSY;
          endcase
        end
        PH_BUSY: if (done) begin
          phase <= PH_DELAY;
          if (!is_init && hi) begin
            hi  <= 1'b0;
            cnt <= W_NIB;
          end else begin
            hi  <= 1'b1;
            cnt <= W_CMD;
            case (state)
              INIT_3A: begin state <= INIT_3B; cnt <= W_I1; end
              INIT_3B: begin state <= INIT_3C; cnt <= W_I2; end
              INIT_3C: state <= INIT_2;
              INIT_2:  begin state <= CFG; cfg_i <= 2'd0; end
              CFG: if (cfg_i == 2'd3) begin
                state <= SNAP;
                cnt   <= W_CLR;
              end else begin
                cfg_i <= cfg_i + 2'd1;
              end
              ADDR1: begin state <= LINE1; col <= 4'd0; end
              LINE1: if (col == 4'd15) state <= ADDR2;
                     else col <= col + 4'd1;
              ADDR2: begin state <= LINE2; col <= 4'd0; end
              LINE2: if (col == 4'd15) begin
                state <= DONE;
                cnt   <= W_END;
              end else begin
                col <= col + 4'd1;
              end
              default: ;
            endcase
          end
        end
        default: phase <= PH_LOAD;
      endcase
    end
  end

  assign lcd_rw = 1'b0;

  lcd_nibble_writer #(
    .T_SETUP (T_SETUP),
    .T_EHIGH (T_EHIGH)
  ) u_nib (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rs     (rs_cur),
    .nibble (nib),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_4  (lcd_4),
    .lcd_5  (lcd_5),
    .lcd_6  (lcd_6),
    .lcd_7  (lcd_7),
    .done   (done)
  );

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: decodes the LCD pin activity into a nibble stream
// and compares it, with its timing, against an expected stream built from chars.
module tb_lcd_text_driver;

  localparam int T_POWERUP = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 30;
  localparam int T_SETUP   = 2;
  localparam int T_EHIGH   = 12;
  localparam int T_NIBGAP  = 5;
  localparam int LIMIT     = 20000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] chars;
  logic         frame_done, lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;
  logic [3:0]   d;

  assign d = {lcd_7, lcd_6, lcd_5, lcd_4};

  lcd_text_driver #(
    .T_POWERUP (T_POWERUP), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2),
    .T_CMD (T_CMD), .T_CLEAR (T_CLEAR), .T_SETUP (T_SETUP),
    .T_EHIGH (T_EHIGH), .T_NIBGAP (T_NIBGAP)
  ) dut (
    .clk (clk), .rst_n (rst_n), .chars (chars), .frame_done (frame_done),
    .lcd_rs (lcd_rs), .lcd_rw (lcd_rw), .lcd_e (lcd_e),
    .lcd_4 (lcd_4), .lcd_5 (lcd_5), .lcd_6 (lcd_6), .lcd_7 (lcd_7)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected nibble stream: what the panel must see, and the idle time after it.
  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
    int         wt;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    frame_no, pos, fd_count, fd_total = 0;
  bit    in_frame, have_prev, hold_bad, rw_seen = 0;
  logic  prev_e = 1'b0, prev_fd = 1'b0, prev_rst = 1'b0;
  int    high_len, fall_cyc, last_wait, rel_cyc, stab = 0;
  logic [4:0] cap, last_rd = '0;

  always @(posedge clk) cyc++;

  function automatic void push_byte(input logic rs, input logic [7:0] b);
    q.push_back('{rs, b[7:4], T_NIBGAP});
    q.push_back('{rs, b[3:0], (!rs && b == 8'h01) ? T_CLEAR : T_CMD});
  endfunction

  function automatic void init_model();
    q.delete();
    q.push_back('{1'b0, 4'h3, T_INIT1});
    q.push_back('{1'b0, 4'h3, T_INIT2});
    q.push_back('{1'b0, 4'h3, T_CMD});
    q.push_back('{1'b0, 4'h2, T_CMD});
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    frame_no  = 0;
    pos       = 0;
    fd_count  = 0;
    in_frame  = 0;
    have_prev = 0;
  endfunction

  task automatic append_frame();
    check("fd_before_frame", fd_count, frame_no);
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, chars[255 - 8*i -: 8]);
    push_byte(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_byte(1'b1, chars[255 - 8*i -: 8]);
    frame_no++;
    pos      = 0;
    in_frame = 1;
  endtask

  always @(negedge clk) begin
    item_t it;
    if (lcd_rw) rw_seen = 1;
    if ({lcd_rs, d} == last_rd) stab++;
    else stab = 1;
    last_rd = {lcd_rs, d};
    if (!rst_n) begin
      init_model();
      prev_e   = 1'b0;
      prev_fd  = 1'b0;
      prev_rst = 1'b0;
    end else begin
      if (!prev_rst) rel_cyc = cyc;
      prev_rst = 1'b1;
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) append_frame();
        it = q.pop_front();
        check("nibble_rs_data", {lcd_rs, d}, {it.rs, it.nib});
        if (have_prev) check("gap_fall_to_rise", cyc - fall_cyc, last_wait + T_SETUP);
        else           check("powerup_to_rise", cyc - rel_cyc, T_POWERUP + T_SETUP);
        check("setup_stable", stab >= T_SETUP + 1, 1);
        cap       = {lcd_rs, d};
        high_len  = 1;
        hold_bad  = 0;
        last_wait = it.wt;
        have_prev = 1;
        if (in_frame) pos++;
      end else if (lcd_e) begin
        high_len++;
        if ({lcd_rs, d} != cap) hold_bad = 1;
      end else if (prev_e) begin
        check("e_high_len", high_len, T_EHIGH);
        check("hold_after_fall", {hold_bad, lcd_rs, d}, {1'b0, cap});
        fall_cyc = cyc;
      end
      if (frame_done) begin
        check("fd_after_last_char", q.size(), 0);
        check("fd_single_cycle", prev_fd, 0);
        fd_count++;
        fd_total++;
      end
      prev_e  = lcd_e;
      prev_fd = frame_done;
    end
  end

  task automatic wait_fd(input int target, input string tag);
    int n = 0;
    while (fd_total < target && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, fd_total >= target, 1);
  endtask

  task automatic wait_pos(input int fno, input int p, input bit need_e, input string tag);
    int n = 0;
    while (!(in_frame && frame_no == fno && pos >= p && (!need_e || lcd_e)) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n < LIMIT, 1);
  endtask

  function automatic logic [255:0] rand_chars();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    r[255:248] = 8'h00;
    r[7:0]     = 8'hFF;
    r[127:120] = 8'h01;
    return r;
  endfunction

  initial begin
    logic [255:0] txt;
    int base;
    rst_n = 1'b0;
    txt   = {"THIEN21119358 ", {18{8'h20}}};
    chars = txt;
    repeat (5) @(posedge clk);
    #1;
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", d, 0);
    check("rst_frame_done", frame_done, 0);

    rst_n = 1'b1;
    wait_fd(1, "frame1_done");
    wait_pos(2, 10, 0, "reach_frame2_line1");
    chars = rand_chars();
    wait_fd(2, "frame2_done");
    wait_pos(3, 12, 0, "reach_frame3_line1");
    chars = rand_chars();
    wait_fd(3, "frame3_done");
    wait_fd(4, "frame4_done");

    wait_pos(5, 40, 1, "reach_line2_e_high");
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_e", lcd_e, 0);
    check("midrst_rs", lcd_rs, 0);
    check("midrst_data", d, 0);
    check("midrst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1;
    chars = rand_chars();
    base  = fd_total;
    rst_n = 1'b1;
    wait_fd(base + 1, "frame_after_reset_done");
    wait_fd(base + 2, "frame2_after_reset_done");

    check("rw_never_high", rw_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
